fb_scanout: RTL

Frame-buffer store and raster reader that sits on the pixel-write side of the GPU. It accepts the GPU's `fb_x`/`fb_y`/`fb_color`/`fb_write` pixel writes into on-chip RAM. On request, it streams the stored frame out in raster order over a valid/ready interface to the display driver. Optional double buffering lets the GPU draw into a back buffer while the front buffer is scanned.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_ram.sv | 33 +++
 rtl/fb_scanout.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types and sizing for the frame-buffer scanout block.
// Pure declarations: no latency, no flow control.
// The address-width helper sizes RAM for one or two frames.
package fb_pkg;

    localparam int FB_WIDTH_DEF  = 120;
    localparam int FB_HEIGHT_DEF = 160;

    typedef logic [15:0] color_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } scan_state_e;

    typedef struct packed {
        color_t pix;
        logic   sof;
        logic   eol;
    } beat_t;

    function automatic int fb_addr_w(input int nbuf, input int w, input int h);
        return $clog2(nbuf * w * h);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port frame RAM: one write port, one synchronous read port.
// Read data appears one cycle after rd_en; a same-address write returns old data.
// No backpressure: both ports accept every cycle.
module fb_ram
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_WIDTH_DEF * FB_HEIGHT_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  color_t        wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output color_t        rd_dat
);

    color_t mem [DEPTH];
    color_t rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer store plus raster reader; FB_DOUBLE_BUFFER_EN adds front/back buffers with swap.
// Latency: scan_start at edge N gives the first beat after edge N+2, then one beat per cycle.
// Backpressure: a 2-entry skid buffer absorbs the RAM read latency; reads throttle on out_ready.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  fb_x,
    input  logic [7:0]  fb_y,
    input  logic [15:0] fb_color,
    input  logic        fb_write,
    input  logic        scan_start,
    input  logic        swap_req,
    output logic        swap_done,
    output logic        busy,
    output logic [15:0] out_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol
);

`ifdef FB_DOUBLE_BUFFER_EN
    localparam int NBUF = 2;
`else
    localparam int NBUF = 1;
`endif
    localparam int NPIX = FB_WIDTH * FB_HEIGHT;
    localparam int AW   = fb_addr_w(NBUF, FB_WIDTH, FB_HEIGHT);
    typedef logic [AW-1:0] addr_t;

    scan_state_e state_q, state_d;
    logic [7:0]  rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    addr_t       rd_addr_q, rd_addr_d;
    logic        pend_vld_q, pend_vld_d;
    logic        pend_sof_q, pend_sof_d, pend_eol_q, pend_eol_d;
    beat_t       ent_q [2];
    beat_t       ent_d [2];
    logic [1:0]  cnt_q, cnt_d;
    logic        swap_done_q, swap_done_d;

    logic        pop, rd_en, wr_en, rd_last;
    logic [1:0]  after_pop, occ;
    addr_t       wr_base, rd_base, wr_addr;
    color_t      ram_rd_dat;
    beat_t       push_beat;

`ifdef FB_DOUBLE_BUFFER_EN
    logic front_q, front_d, swap_pend_q, swap_pend_d;
    assign wr_base = front_q ? addr_t'(0) : addr_t'(NPIX);
    assign rd_base = front_q ? addr_t'(NPIX) : addr_t'(0);
`else
    logic unused_swap_req;
    assign unused_swap_req = swap_req;
    assign wr_base = '0;
    assign rd_base = '0;
`endif

    assign wr_en   = fb_write && (int'(fb_x) < FB_WIDTH) && (int'(fb_y) < FB_HEIGHT);
    assign wr_addr = addr_t'(fb_y) * addr_t'(FB_WIDTH) + addr_t'(fb_x) + wr_base;

    // Occupancy once this cycle's pop and arriving read data settle; one slot must remain free to issue.
    assign pop       = (cnt_q != 2'd0) && out_ready;
    assign after_pop = cnt_q - 2'(pop);
    assign occ       = after_pop + 2'(pend_vld_q);
    assign rd_en     = (state_q == ST_SCAN) && (occ < 2'd2);
    assign rd_last   = (rd_addr_q == addr_t'(NPIX - 1));
    assign push_beat = '{pix: ram_rd_dat, sof: pend_sof_q, eol: pend_eol_q};

    always_comb begin
        state_d     = state_q;
        rd_x_d      = rd_x_q;
        rd_y_d      = rd_y_q;
        rd_addr_d   = rd_addr_q;
        pend_vld_d  = rd_en;
        pend_sof_d  = pend_sof_q;
        pend_eol_d  = pend_eol_q;
        ent_d       = ent_q;
        cnt_d       = occ;
        swap_done_d = 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
        front_d     = front_q;
        swap_pend_d = swap_pend_q || (swap_req && (state_q != ST_IDLE));
`endif

        if (pop) begin
            ent_d[0] = ent_q[1];
        end
        if (pend_vld_q) begin
            if (after_pop == 2'd0) begin
                ent_d[0] = push_beat;
            end else begin
                ent_d[1] = push_beat;
            end
        end

        if (rd_en) begin
            pend_sof_d = (rd_x_q == 8'd0) && (rd_y_q == 8'd0);
            pend_eol_d = (rd_x_q == 8'(FB_WIDTH - 1));
            rd_addr_d  = rd_addr_q + addr_t'(1);
            if (rd_x_q == 8'(FB_WIDTH - 1)) begin
                rd_x_d = 8'd0;
                rd_y_d = rd_y_q + 8'd1;
            end else begin
                rd_x_d = rd_x_q + 8'd1;
            end
            if (rd_last) begin
                state_d = ST_DRAIN;
            end
        end

        case (state_q)
            ST_IDLE: begin
`ifdef FB_DOUBLE_BUFFER_EN
                // Swap before a simultaneous start so the scan reads the new front buffer.
                if (swap_req || swap_pend_q) begin
                    front_d     = !front_q;
                    swap_pend_d = 1'b0;
                    swap_done_d = 1'b1;
                end
`endif
                if (scan_start) begin
                    state_d   = ST_SCAN;
                    rd_x_d    = 8'd0;
                    rd_y_d    = 8'd0;
                    rd_addr_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!pend_vld_q && (occ == 2'd0)) begin
                    state_d = ST_IDLE;
`ifdef FB_DOUBLE_BUFFER_EN
                    if (swap_req || swap_pend_q) begin
                        front_d     = !front_q;
                        swap_pend_d = 1'b0;
                        swap_done_d = 1'b1;
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rd_x_q      <= 8'd0;
            rd_y_q      <= 8'd0;
            rd_addr_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_sof_q  <= 1'b0;
            pend_eol_q  <= 1'b0;
            ent_q[0]    <= '0;
            ent_q[1]    <= '0;
            cnt_q       <= 2'd0;
            swap_done_q <= 1'b0;
`ifdef FB_DOUBLE_BUFFER_EN
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_x_q      <= rd_x_d;
            rd_y_q      <= rd_y_d;
            rd_addr_q   <= rd_addr_d;
            pend_vld_q  <= pend_vld_d;
            pend_sof_q  <= pend_sof_d;
            pend_eol_q  <= pend_eol_d;
            ent_q[0]    <= ent_d[0];
            ent_q[1]    <= ent_d[1];
            cnt_q       <= cnt_d;
            swap_done_q <= swap_done_d;
`ifdef FB_DOUBLE_BUFFER_EN
            front_q     <= front_d;
            swap_pend_q <= swap_pend_d;
`endif
        end
    end

    fb_ram #(
        .DEPTH (NBUF * NPIX),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (fb_color),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q + rd_base),
        .rd_dat  (ram_rd_dat)
    );

    assign out_valid = (cnt_q != 2'd0);
    assign out_pixel = ent_q[0].pix;
    assign out_sof   = out_valid && ent_q[0].sof;
    assign out_eol   = out_valid && ent_q[0].eol;
    assign busy      = (state_q != ST_IDLE);
    assign swap_done = swap_done_q;

endmodule
